dmem_io_responder: RTL and testbench
====================================

Name: dmem_io_responder

Overview:
- Data-memory responder for the pipelined PMIPS core.
- Answers the core's dmem read/write strobes with word RAM plus memory-mapped IO: a 7-segment display register, and switch inputs that are synchronized and debounced.
- Sits between the core's MEM stage and the board IO pins.
- Read data is combinational, so the MEM stage completes in one cycle.

Parameters:
- RAM_WORDS, 128: number of 16-bit RAM words; power of two, maximum 16384.
- DEBOUNCE_CYCLES, 4: consecutive stable synchronized cycles required before a switch level is accepted; minimum 1.

Ports:
- clock  input  1  single system clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-low reset.
- addr  input  16  byte address from the core; bit 0 ignored (16-bit words).
- wdata  input  16  write data.
- write  input  1  write enable, sampled at rising edge.
- read  input  1  read enable.
- rdata  output  16  read data, combinational from addr and read.
- sw0  input  1  raw, asynchronous board switch 0.
- sw1  input  1  raw, asynchronous board switch 1.
- display  output  7  segments g..a (bit6..bit0), active-low.

Behaviour:
Address map (word index = addr[15:1]):
- 0x0000 up to 2*RAM_WORDS-2: RAM, read/write.
- 0xFFF0 DISP: read/write. Write stores wdata[3:0]. Read returns {12'b0, digit}.
- 0xFFF2 SW: read-only. Returns {14'b0, sw1_db, sw0_db}.
- 0xFFF4 CHG: read-only. Returns {14'b0, chg1, chg0}. Clear-on-read.
- Any other address: reads return 0; writes are ignored. Writes to SW and CHG are also ignored.

Reads:
- rdata = mapped value when read=1, else 0. No latency.
- Read and write to the same address in the same cycle: rdata shows the old value; the new value is visible after the edge.
- read and write both high: the write is performed and rdata is still driven.

RAM:
- Write occurs at the rising edge when write=1.
- Contents are not reset; initial contents are X.

Reset (asynchronous, reset=0):
- digit=0, so display=7'h40 (shows "0").
- Synchronizer flops = 0, sw*_db = 0, debounce counters = 0, chg* = 0.
- rdata is combinational and therefore follows the reset register values.
- Reset asserted mid-debounce discards the pending count.

Switch path, per switch:
- Two-flop synchronizer feeds sync.
- If sync == db, the counter clears.
- Otherwise the counter increments. When counter == DEBOUNCE_CYCLES-1 on that edge, db <= sync, the counter clears, and chg <= 1.
- A glitch shorter than DEBOUNCE_CYCLES synchronized cycles never reaches db.
- Latency from a raw change to db change is 2 + DEBOUNCE_CYCLES edges.
- Counter width is clog2(DEBOUNCE_CYCLES)+1; it never wraps.

CHG clear-on-read:
- At the rising edge where read=1 and the address decodes to CHG, both chg bits clear.
- If a new debounce event occurs on the same edge, that bit's set wins.

Display:
- display = seven-segment decode of digit for 0..F, active-low.
- Decodes: 0=40, 1=79, 2=24, 3=30, 4=19, 5=12, 6=02, 7=78, 8=00, 9=10, A=08, b=03, C=46, d=21, E=06, F=0E (hex).

Decomposition:
- Shared package pmips_io_pkg holds:
  - address constants ADDR_DISP=16'hFFF0, ADDR_SW=16'hFFF2, ADDR_CHG=16'hFFF4;
  - the display reset pattern SEG_ZERO=7'h40.
- One sub-module: switch_debounce (synchronizer, counter, db, change pulse), instantiated once per switch.
- Hex-to-segment decode stays inline as a case statement.

Test Plan:
- Async reset: drop reset mid-clock with sw0=1 held -> display=7'h40 immediately, SW read returns 0, CHG returns 0.
- RAM: write 16'hBEEF to 0x0010, then read 0x0010 -> 16'hBEEF. Same-cycle write 16'h1234 with read of 0x0010 -> rdata=BEEF that cycle, 1234 the next.
- Display: write 16'h00A7 to 0xFFF0 -> display=7'h78 and DISP read = 16'h0007. Write to 0xFFF2 -> SW is unchanged.
- Debounce, DEBOUNCE_CYCLES=4: raise sw1 and hold -> SW reads 16'h0002 after exactly 6 edges, CHG reads 16'h0002, and a second CHG read returns 0. A 3-cycle sw0 pulse -> SW stays 0 and CHG stays 0.
- Set-wins: time a CHG read on the edge where sw0 debounces -> next CHG read returns 16'h0001.
- Unmapped: read 0x8000 -> 0; read=0 at any address -> rdata=0.

Source files
------------

// File: rtl/pmips_io_pkg.sv
// Shared PMIPS IO definitions: memory-mapped register addresses, the display
// reset pattern and the dmem address-decode select.
package pmips_io_pkg;

    localparam logic [15:0] ADDR_DISP = 16'hFFF0;
    localparam logic [15:0] ADDR_SW   = 16'hFFF2;
    localparam logic [15:0] ADDR_CHG  = 16'hFFF4;
    localparam logic [6:0]  SEG_ZERO  = 7'h40;
    localparam int          NUM_SW    = 2;

    typedef enum logic [2:0] {
        SEL_NONE,
        SEL_RAM,
        SEL_DISP,
        SEL_SW,
        SEL_CHG
    } dmem_sel_e;

    // Addresses are compared as 16-bit word indices; the byte bit is ignored.
    function automatic logic word_match(logic [15:0] a, logic [15:0] b);
        return a[15:1] == b[15:1];
    endfunction

endpackage

// File: rtl/switch_debounce.sv
// One board switch: two-flop synchronizer, then a level is accepted only after
// DEBOUNCE_CYCLES consecutive synchronized cycles that disagree with it.
module switch_debounce #(
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic clock,
    input  logic reset,
    input  logic raw,
    output logic db,
    output logic fire
);
    localparam int CW = $clog2(DEBOUNCE_CYCLES) + 1;
    localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic [1:0]    sync_ff;
    logic [CW-1:0] cnt;
    logic          sync;

    assign sync = sync_ff[1];
    // fire marks the edge on which db takes the new level.
    assign fire = (sync != db) && (cnt == LAST);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            sync_ff <= '0;
            cnt     <= '0;
            db      <= 1'b0;
        end else begin
            sync_ff <= {sync_ff[0], raw};
            if (sync == db || fire) cnt <= '0;
            else                    cnt <= cnt + CW'(1);
            if (fire) db <= sync;
        end
    end

endmodule

// File: rtl/dmem_io_responder.sv
// PMIPS dmem responder: word RAM plus memory-mapped 7-segment display and
// debounced switches, with combinational read data for a one-cycle MEM stage.
module dmem_io_responder
    import pmips_io_pkg::*;
#(
    parameter int RAM_WORDS       = 128,
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [15:0] addr,
    input  logic [15:0] wdata,
    input  logic        write,
    input  logic        read,
    output logic [15:0] rdata,
    input  logic        sw0,
    input  logic        sw1,
    output logic [6:0]  display
);
    localparam int AW = $clog2(RAM_WORDS);

    dmem_sel_e          sel;
    logic [15:0]        mem [RAM_WORDS];
    logic [3:0]         digit;
    logic [NUM_SW-1:0]  raw_sw, sw_db, sw_fire, chg;
    logic               chg_clr;
    logic               unused_ok;

    // The byte bit of the address never selects anything.
    assign unused_ok = &{1'b0, addr[0]};

    always_comb begin
        sel = SEL_NONE;
        if ({1'b0, addr[15:1]} < 16'(RAM_WORDS)) sel = SEL_RAM;
        else if (word_match(addr, ADDR_DISP))    sel = SEL_DISP;
        else if (word_match(addr, ADDR_SW))      sel = SEL_SW;
        else if (word_match(addr, ADDR_CHG))     sel = SEL_CHG;
    end

    always_ff @(posedge clock) begin
        if (write && sel == SEL_RAM) mem[addr[AW:1]] <= wdata;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset)                        digit <= 4'h0;
        else if (write && sel == SEL_DISP) digit <= wdata[3:0];
    end

    assign raw_sw = {sw1, sw0};

    for (genvar i = 0; i < NUM_SW; i++) begin : g_sw
        switch_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db (
            .clock (clock),
            .reset (reset),
            .raw   (raw_sw[i]),
            .db    (sw_db[i]),
            .fire  (sw_fire[i])
        );
    end

    // A debounce event on the clearing edge wins over the clear.
    assign chg_clr = read && sel == SEL_CHG;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            chg <= '0;
        end else begin
            for (int i = 0; i < NUM_SW; i++) begin
                if (sw_fire[i])   chg[i] <= 1'b1;
                else if (chg_clr) chg[i] <= 1'b0;
            end
        end
    end

    always_comb begin
        rdata = '0;
        if (read) begin
            case (sel)
                SEL_RAM:  rdata = mem[addr[AW:1]];
                SEL_DISP: rdata = {12'b0, digit};
                SEL_SW:   rdata = {14'b0, sw_db};
                SEL_CHG:  rdata = {14'b0, chg};
                default:  rdata = '0;
            endcase
        end
    end

    always_comb begin
        display = SEG_ZERO;
        case (digit)
            4'h0: display = 7'h40;
            4'h1: display = 7'h79;
            4'h2: display = 7'h24;
            4'h3: display = 7'h30;
            4'h4: display = 7'h19;
            4'h5: display = 7'h12;
            4'h6: display = 7'h02;
            4'h7: display = 7'h78;
            4'h8: display = 7'h00;
            4'h9: display = 7'h10;
            4'hA: display = 7'h08;
            4'hB: display = 7'h03;
            4'hC: display = 7'h46;
            4'hD: display = 7'h21;
            4'hE: display = 7'h06;
            4'hF: display = 7'h0E;
            default: display = SEG_ZERO;
        endcase
    end

endmodule

// File: tb/tb_dmem_io_responder.sv
// Directed plus randomized bench for dmem_io_responder against a behavioural
// model of the memory map, display decode and switch debouncing.
module tb_dmem_io_responder;
    localparam int D  = 4;
    localparam int RW = 128;

    logic        clock, reset, write, read, sw0, sw1;
    logic [15:0] addr, wdata, rdata;
    logic [6:0]  display;

    int errors = 0;
    int checks = 0;

    dmem_io_responder #(.RAM_WORDS(RW), .DEBOUNCE_CYCLES(D)) dut (
        .clock(clock), .reset(reset), .addr(addr), .wdata(wdata),
        .write(write), .read(read), .rdata(rdata),
        .sw0(sw0), .sw1(sw1), .display(display)
    );

    always #5 clock = ~clock;

    // Reference state
    logic [15:0] ram_m [int];
    logic [3:0]  m_digit;
    logic [1:0]  m_db, m_chg, m_s0, m_s1;
    logic [31:0] m_h [2];
    int          m_n [2];

    function automatic logic [6:0] seg_of(logic [3:0] d);
        case (d)
            4'h0: return 7'h40; 4'h1: return 7'h79; 4'h2: return 7'h24; 4'h3: return 7'h30;
            4'h4: return 7'h19; 4'h5: return 7'h12; 4'h6: return 7'h02; 4'h7: return 7'h78;
            4'h8: return 7'h00; 4'h9: return 7'h10; 4'hA: return 7'h08; 4'hB: return 7'h03;
            4'hC: return 7'h46; 4'hD: return 7'h21; 4'hE: return 7'h06; default: return 7'h0E;
        endcase
    endfunction

    task automatic model_reset();
        m_digit = 0; m_db = 0; m_chg = 0; m_s0 = 0; m_s1 = 0;
        for (int i = 0; i < 2; i++) begin m_h[i] = 0; m_n[i] = 0; end
    endtask

    // Expected read data; known=0 where the RAM word was never written.
    task automatic exp_rdata(output logic [15:0] v, output bit known);
        int w;
        w = int'(addr) / 2;
        v = 16'h0; known = 1;
        if (!read) return;
        if (w < RW) begin
            if (ram_m.exists(w)) v = ram_m[w];
            else known = 0;
        end
        else if (w == 16'hFFF0 / 2) v = {12'h0, m_digit};
        else if (w == 16'hFFF2 / 2) v = {14'h0, m_db};
        else if (w == 16'hFFF4 / 2) v = {14'h0, m_chg};
    endtask

    // Apply the effect of the coming rising edge using the current inputs.
    task automatic model_step();
        int   w;
        bit   fire [2];
        logic [31:0] mask, tgt;
        w = int'(addr) / 2;
        mask = (32'd1 << D) - 1;
        for (int i = 0; i < 2; i++) begin
            m_h[i] = {m_h[i][30:0], m_s1[i]};
            if (m_n[i] < 32) m_n[i]++;
            tgt = m_db[i] ? 32'd0 : mask;
            fire[i] = (m_n[i] >= D) && ((m_h[i] & mask) == tgt);
        end
        for (int i = 0; i < 2; i++) begin
            if (fire[i]) begin m_db[i] = ~m_db[i]; m_chg[i] = 1'b1; end
            else if (read && w == 16'hFFF4 / 2) m_chg[i] = 1'b0;
        end
        m_s1 = m_s0;
        m_s0 = {sw1, sw0};
        if (write) begin
            if (w < RW) ram_m[w] = wdata;
            else if (w == 16'hFFF0 / 2) m_digit = wdata[3:0];
        end
    endtask

    task automatic chk(string tag, logic [15:0] obs, logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        model_step();
        @(posedge clock);
        #1;
    endtask

    task automatic rd_chk(string tag, logic [15:0] a);
        logic [15:0] e; bit k;
        addr = a; read = 1; write = 0;
        #1;
        exp_rdata(e, k);
        if (k) chk(tag, rdata, e);
    endtask

    task automatic wr(logic [15:0] a, logic [15:0] d);
        addr = a; wdata = d; write = 1; read = 0;
        cyc();
        write = 0;
    endtask

    task automatic idle(int n);
        read = 0; write = 0;
        for (int i = 0; i < n; i++) cyc();
    endtask

    initial begin
        logic [15:0] e; bit k;
        clock = 0; reset = 0; addr = 0; wdata = 0; write = 0; read = 0; sw0 = 0; sw1 = 0;
        model_reset();
        #3;
        chk("reset_display", {9'h0, display}, 16'h0040);
        rd_chk("reset_sw", 16'hFFF2);
        rd_chk("reset_chg", 16'hFFF4);
        read = 0;
        #3 reset = 1;

        // Async reset mid-clock with sw0 held and a debounced level present
        sw0 = 1;
        wr(16'hFFF0, 16'h0005);
        idle(9);
        rd_chk("pre_rst_sw", 16'hFFF2);
        chk("pre_rst_sw_const", rdata, 16'h0001);
        #3 reset = 0; model_reset();
        #1;
        chk("async_rst_display", {9'h0, display}, 16'h0040);
        rd_chk("async_rst_sw", 16'hFFF2);
        chk("async_rst_sw_const", rdata, 16'h0000);
        rd_chk("async_rst_chg", 16'hFFF4);
        chk("async_rst_chg_const", rdata, 16'h0000);
        sw0 = 0; read = 0;
        reset = 1;
        idle(8);

        // RAM write/read and same-cycle read-old-value
        wr(16'h0010, 16'hBEEF);
        rd_chk("ram_rd", 16'h0010);
        chk("ram_rd_const", rdata, 16'hBEEF);
        wdata = 16'h1234; write = 1;
        #1;
        chk("ram_rw_old", rdata, 16'hBEEF);
        cyc();
        rd_chk("ram_rw_new", 16'h0010);
        chk("ram_rw_new_const", rdata, 16'h1234);

        // Display register, and writes to read-only SW ignored
        wr(16'hFFF0, 16'h00A7);
        chk("disp_seg", {9'h0, display}, 16'h0078);
        rd_chk("disp_rd", 16'hFFF0);
        chk("disp_rd_const", rdata, 16'h0007);
        wr(16'hFFF2, 16'hFFFF);
        rd_chk("sw_ro", 16'hFFF2);
        chk("sw_ro_const", rdata, 16'h0000);

        // sw1 debounce latency: exactly 2+D edges
        sw1 = 1;
        for (int n = 1; n <= 6; n++) begin
            addr = 16'hFFF2; read = 1;
            cyc();
            rd_chk("sw1_latency", 16'hFFF2);
            chk("sw1_latency_const", rdata, (n >= 6) ? 16'h0002 : 16'h0000);
        end
        rd_chk("chg_set", 16'hFFF4);
        chk("chg_set_const", rdata, 16'h0002);
        cyc();
        rd_chk("chg_cleared", 16'hFFF4);
        chk("chg_cleared_const", rdata, 16'h0000);

        // Short sw0 glitch never reaches db
        read = 0;
        sw0 = 1; idle(3); sw0 = 0; idle(8);
        rd_chk("glitch_sw", 16'hFFF2);
        chk("glitch_sw_const", rdata, 16'h0002);
        rd_chk("glitch_chg", 16'hFFF4);
        chk("glitch_chg_const", rdata, 16'h0000);

        // Set wins over clear-on-read on the debounce edge
        sw0 = 1; idle(5);
        rd_chk("setwin_pre", 16'hFFF4);
        chk("setwin_pre_const", rdata, 16'h0000);
        cyc();
        rd_chk("setwin_post", 16'hFFF4);
        chk("setwin_post_const", rdata, 16'h0001);

        // Unmapped and read=0
        rd_chk("unmapped", 16'h8000);
        chk("unmapped_const", rdata, 16'h0000);
        read = 0; addr = 16'hFFF2; #1;
        chk("noread_sw", rdata, 16'h0000);
        addr = 16'h0010; #1;
        chk("noread_ram", rdata, 16'h0000);
        cyc();

        // Randomized traffic with switch bouncing
        for (int it = 0; it < 500; it++) begin
            case ($urandom_range(0, 5))
                0, 1: addr = 16'($urandom_range(0, 15) * 2 + $urandom_range(0, 1));
                2:    addr = 16'($urandom_range(0, RW - 1) * 2);
                3:    addr = 16'hFFF0 | 16'($urandom_range(0, 1));
                4:    addr = ($urandom_range(0, 1) != 0) ? 16'hFFF2 : 16'hFFF4;
                default: addr = 16'($urandom_range(256, 65519));
            endcase
            wdata = 16'($urandom);
            read  = 1'($urandom_range(0, 1));
            write = ($urandom_range(0, 2) == 0);
            if ($urandom_range(0, 9) == 0) sw0 = ~sw0;
            if ($urandom_range(0, 9) == 0) sw1 = ~sw1;
            #1;
            exp_rdata(e, k);
            if (k) chk("rand_rdata", rdata, e);
            chk("rand_display", {9'h0, display}, {9'h0, seg_of(m_digit)});
            cyc();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
